// File: rtl/load_control_queue.sv
// load_control_queue: buffers decoded operand-load codes and emits one registered load select per enabled cycle
module load_control_queue #(
  parameter int SEL_W = 4,
  parameter int DEPTH = 2,
  parameter logic [SEL_W-1:0] NOOP_CODE = '0,
  parameter int CNT_W = 8
) (
  input  logic                     clk,
  input  logic                     reset,
  input  logic                     enable,
  input  logic                     flush,
  input  logic                     in_valid,
  output logic                     in_ready,
  input  logic [SEL_W-1:0]         in_sel,
  input  logic [SEL_W-1:0]         in_sel2,
  input  logic                     in_split,
  input  logic                     in_gated,
  input  logic                     cond_result,
  output logic [SEL_W-1:0]         out_sel,
  output logic                     out_busy,
  output logic [$clog2(DEPTH):0]   count,
  output logic [CNT_W-1:0]         drop_count
);
  localparam int AW = $clog2(DEPTH);
  localparam int CW = AW + 1;
  localparam logic [CW-1:0] FULL = CW'(DEPTH);
  localparam logic [0:0] IDLE = 1'b0;
  localparam logic [0:0] SECOND = 1'b1;

  logic [SEL_W-1:0] sel_q [DEPTH];
  logic [SEL_W-1:0] sel2_q [DEPTH];
  logic             split_q [DEPTH];
  logic [AW-1:0]    wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
  logic [CW-1:0]    count_q, count_d;
  logic [0:0]       state_q, state_d;
  logic [SEL_W-1:0] out_sel_q, out_sel_d;
  logic [CNT_W-1:0] drop_q, drop_d;
  logic accept, drop, push, pop, empty, run;

  // handshake, queue bookkeeping and next-state selection; flush outranks the stall
  always_comb begin
    run      = enable & ~flush;
    empty    = count_q == '0;
    in_ready = run & (count_q < FULL);
    accept   = in_valid & in_ready;
    drop     = accept & in_gated & ~cond_result;
    push     = accept & ~drop;
    pop      = run & ~empty & ((state_q == SECOND) | ~split_q[rd_ptr_q]);
    wr_ptr_d = flush ? '0 : wr_ptr_q + AW'(push);
    rd_ptr_d = flush ? '0 : rd_ptr_q + AW'(pop);
    count_d  = flush ? '0 : count_q + CW'(push) - CW'(pop);
    drop_d   = (drop & ~&drop_q) ? drop_q + CNT_W'(1) : drop_q;
    state_d  = ~run ? (flush ? IDLE : state_q) :
               (state_q == IDLE & ~empty & split_q[rd_ptr_q]) ? SECOND : IDLE;
    out_sel_d = flush ? NOOP_CODE : ~enable ? out_sel_q :
                (state_q == SECOND) ? sel2_q[rd_ptr_q] :
                empty ? NOOP_CODE : sel_q[rd_ptr_q];
  end

  // control state, pointers, occupancy and output register
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      wr_ptr_q  <= '0;
      rd_ptr_q  <= '0;
      count_q   <= '0;
      state_q   <= IDLE;
      out_sel_q <= NOOP_CODE;
      drop_q    <= '0;
    end else begin
      wr_ptr_q  <= wr_ptr_d;
      rd_ptr_q  <= rd_ptr_d;
      count_q   <= count_d;
      state_q   <= state_d;
      out_sel_q <= out_sel_d;
      drop_q    <= drop_d;
    end
  end

  // entry storage needs no reset: only slots written since the last reset are ever read
  always_ff @(posedge clk) begin
    if (push) begin
      sel_q[wr_ptr_q]   <= in_sel;
      sel2_q[wr_ptr_q]  <= in_sel2;
      split_q[wr_ptr_q] <= in_split;
    end
  end

  assign out_sel    = out_sel_q;
  assign count      = count_q;
  assign drop_count = drop_q;
  assign out_busy   = (count_q != '0) | (state_q != IDLE);
endmodule

// File: tb/tb_load_control_queue.sv
// tb_load_control_queue: directed checks of the load-control queue
module tb_load_control_queue;
  logic clk = 1'b0;
  logic reset, enable, flush, in_valid, in_ready, in_split, in_gated, cond_result, out_busy;
  logic [3:0] in_sel, in_sel2, out_sel;
  logic [1:0] count;
  logic [7:0] drop_count;
  int checks = 0;
  int errors = 0;

  load_control_queue #(.SEL_W(4), .DEPTH(2), .NOOP_CODE(4'd0), .CNT_W(8)) dut (
    .clk(clk), .reset(reset), .enable(enable), .flush(flush),
    .in_valid(in_valid), .in_ready(in_ready), .in_sel(in_sel), .in_sel2(in_sel2),
    .in_split(in_split), .in_gated(in_gated), .cond_result(cond_result),
    .out_sel(out_sel), .out_busy(out_busy), .count(count), .drop_count(drop_count)
  );

  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed %0d expected %0d", tag, obs, exp);
    end
  endtask

  task automatic req(input logic v, input logic [3:0] s, input logic [3:0] s2, input logic sp,
                     input logic g, input logic c);
    in_valid = v; in_sel = s; in_sel2 = s2; in_split = sp; in_gated = g; cond_result = c;
  endtask

  initial begin
    reset = 1'b1; enable = 1'b1; flush = 1'b0;
    req(0, 0, 0, 0, 0, 0);
    tick(); tick();
    chk("rst_out", out_sel, 0);
    chk("rst_count", count, 0);
    chk("rst_busy", out_busy, 0);
    chk("rst_drop", drop_count, 0);
    chk("rst_ready", in_ready, 1);
    reset = 1'b0;
    tick();
    // single code: latency of one edge, one-cycle pulse
    req(1, 5, 0, 0, 0, 0);
    tick();
    chk("single_cnt1", count, 1);
    chk("single_out_n", out_sel, 0);
    chk("single_busy", out_busy, 1);
    req(0, 0, 0, 0, 0, 0);
    tick();
    chk("single_out5", out_sel, 5);
    chk("single_cnt0", count, 0);
    tick();
    chk("single_out0", out_sel, 0);
    chk("single_idle", out_busy, 0);
    // split then plain: 3,7,9,0
    req(1, 3, 7, 1, 0, 0);
    tick();
    req(1, 9, 0, 0, 0, 0);
    tick();
    chk("split_out3", out_sel, 3);
    chk("split_cnt2", count, 2);
    req(0, 0, 0, 0, 0, 0);
    tick();
    chk("split_out7", out_sel, 7);
    chk("split_cnt1", count, 1);
    tick();
    chk("split_out9", out_sel, 9);
    tick();
    chk("split_out0", out_sel, 0);
    chk("split_cnt0", count, 0);
    // gated drops
    req(1, 4, 0, 0, 1, 0);
    for (int i = 0; i < 3; i++) begin
      tick();
      chk("gate_out", out_sel, 0);
      chk("gate_cnt", count, 0);
    end
    req(0, 0, 0, 0, 0, 0);
    tick();
    chk("gate_drop3", drop_count, 3);
    chk("gate_out_q", out_sel, 0);
    req(1, 4, 0, 0, 1, 1);
    tick();
    chk("gate_taken", count, 1);
    req(0, 0, 0, 0, 0, 0);
    tick();
    chk("gate_out4", out_sel, 4);
    chk("gate_drop_h", drop_count, 3);
    tick();
    // three split requests against a two-entry queue
    req(1, 1, 2, 1, 0, 0);
    tick();
    chk("bp_cnt1", count, 1);
    req(1, 3, 4, 1, 0, 0);
    tick();
    chk("bp_out1", out_sel, 1);
    chk("bp_cnt2", count, 2);
    req(1, 5, 6, 1, 0, 0);
    chk("bp_ready0", in_ready, 0);
    tick();
    chk("bp_out2", out_sel, 2);
    chk("bp_cnt1b", count, 1);
    chk("bp_ready1", in_ready, 1);
    tick();
    chk("bp_out3", out_sel, 3);
    chk("bp_cnt2b", count, 2);
    req(0, 0, 0, 0, 0, 0);
    tick();
    chk("bp_out4", out_sel, 4);
    tick();
    chk("bp_out5", out_sel, 5);
    tick();
    chk("bp_out6", out_sel, 6);
    chk("bp_cnt0", count, 0);
    tick();
    chk("bp_out0", out_sel, 0);
    // stall in SECOND then flush while stalled
    req(1, 8, 11, 1, 0, 0);
    tick();
    req(0, 0, 0, 0, 0, 0);
    tick();
    chk("st_out8", out_sel, 8);
    enable = 1'b0;
    for (int i = 0; i < 3; i++) begin
      tick();
      chk("st_hold", out_sel, 8);
      chk("st_cnt", count, 1);
      chk("st_busy", out_busy, 1);
    end
    flush = 1'b1;
    req(1, 2, 0, 0, 0, 0);
    chk("fl_ready", in_ready, 0);
    tick();
    chk("fl_out0", out_sel, 0);
    chk("fl_cnt0", count, 0);
    chk("fl_busy", out_busy, 0);
    chk("fl_drop", drop_count, 3);
    flush = 1'b0; enable = 1'b1;
    req(0, 0, 0, 0, 0, 0);
    tick();
    chk("fl_nosel2a", out_sel, 0);
    tick();
    chk("fl_nosel2b", out_sel, 0);
    // drop counter saturation
    req(1, 4, 0, 0, 1, 0);
    for (int i = 0; i < 260; i++) tick();
    chk("sat_drop", drop_count, 255);
    req(0, 0, 0, 0, 0, 0);
    tick();
    // async reset with two entries queued and FSM in SECOND
    req(1, 12, 13, 1, 0, 0);
    tick();
    req(1, 14, 0, 0, 0, 0);
    tick();
    req(0, 0, 0, 0, 0, 0);
    chk("ar_pre_out", out_sel, 12);
    chk("ar_pre_cnt", count, 2);
    #2 reset = 1'b1;
    #1;
    chk("ar_out", out_sel, 0);
    chk("ar_cnt", count, 0);
    chk("ar_busy", out_busy, 0);
    chk("ar_drop", drop_count, 0);
    tick();
    reset = 1'b0;
    tick();
    chk("ar_after", out_sel, 0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
